onehot_state_reg: RTL
=====================

ONEHOT_STATE_REG -- requirements
Module: onehot_state_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter NUM_STATES, default 5: number of one-hot state bits; legal range 2..32.
REQ-003 Parameter RESET_IDX, default 0: index of the bit set on reset.
REQ-004 Parameter SAFE_IDX, default 0: index of the bit loaded on illegal next state.
REQ-005 Parameter DWELL_W, default 8: width of the dwell counter.
REQ-006 clk  input  1  system clock; all flops rise-edge triggered.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 en  input  1  load enable for nxt_state.
REQ-009 nxt_state  input  NUM_STATES  candidate next state, one-hot expected.
REQ-010 err_clr  input  1  clears sticky error flag.
REQ-011 state  output  NUM_STATES  current one-hot state, registered.
REQ-012 state_idx  output  $clog2(NUM_STATES)  binary index of the set bit in state, combinational from state.
REQ-013 changed  output  1  registered pulse, high the cycle after state took a different value.
REQ-014 err  output  1  sticky flag, set when an illegal nxt_state was loaded.
REQ-015 dwell  output  DWELL_W  cycles spent in the current state, saturating.

Function
REQ-016 nxt_state is legal only when exactly one bit is set; all-zero and multi-bit values are illegal.
REQ-017 en=1 and nxt_state legal: state SHALL take nxt_state at the next rising edge (1-cycle latency).
REQ-018 en=1 and nxt_state illegal: state SHALL take the one-hot value with only SAFE_IDX set; err SHALL be set on the same edge.
REQ-019 en=0: state SHALL hold regardless of nxt_state; no error detection.
REQ-020 changed SHALL be 1 for exactly one cycle after any edge where the new state differs from the old one; an illegal load resolving to the current state SHALL NOT raise changed.
REQ-021 err SHALL stay set until an edge with err_clr=1 and no illegal load; when err_clr and an illegal load coincide, err SHALL stay 1.
REQ-022 dwell SHALL clear to 0 on any edge where state changes; otherwise it SHALL increment each cycle regardless of en and saturate at 2^DWELL_W-1.
REQ-023 state_idx SHALL equal the index of the set bit; since state is always one-hot, no other encoding is defined.
REQ-024 state SHALL never hold a non-one-hot value in any cycle.

Reset
REQ-025 While rst=1: state = bit RESET_IDX only, err=0, changed=0, dwell=0, independent of clk.
REQ-026 Reset asserted mid-transfer SHALL override en, nxt_state and err_clr; the first edge after release SHALL perform normal REQ-017..022 behaviour.
REQ-027 Reset SHALL NOT raise changed, either on assertion or on release.

Configuration
REQ-028 Macro ONEHOT_DWELL_CNT_EN: when defined, the dwell counter is built per REQ-022.
REQ-029 Without ONEHOT_DWELL_CNT_EN, no counter flops SHALL exist; the dwell port SHALL stay present and be driven constant 0.

Structure
REQ-030 Package onehot_pkg SHALL hold the function that converts a one-hot vector to an index, the function that converts an index to a one-hot vector, and the range-check constant for NUM_STATES.
REQ-031 Sub-module onehot_chk (combinational, parameter WIDTH) SHALL produce the legal flag for nxt_state.
REQ-032 Elaboration SHALL fail if NUM_STATES<2, NUM_STATES>32, RESET_IDX>=NUM_STATES or SAFE_IDX>=NUM_STATES.

Verification (NUM_STATES=5, RESET_IDX=0, SAFE_IDX=0, DWELL_W=4)
REQ-033 Assert rst with no clock running -> state=5'b00001, state_idx=0, err=0, dwell=0 immediately.
REQ-034 en=1, nxt_state=5'b00100 -> next cycle state=5'b00100, state_idx=2, changed=1 for one cycle, dwell=0.
REQ-035 From state 5'b00100, en=1, nxt_state=5'b01100 -> state=5'b00001, err=1; then err_clr=1 -> err=0 after one edge.
REQ-036 From state 5'b00001, en=1, nxt_state=5'b00000 -> state unchanged, err=1, changed=0; illegal load with err_clr=1 on the same edge -> err stays 1.
REQ-037 en=0 for 20 cycles with random nxt_state -> state holds, dwell reaches 15 and stays 15; with the macro undefined, dwell stays 0.
REQ-038 Assert rst during a legal load with en=1 -> state=5'b00001 and changed=0 after release; a legal load on the first edge after release completes.

Source files
------------

// File: rtl/onehot_pkg.sv
// ============================================================================
// onehot_pkg : one-hot/index conversion helpers and NUM_STATES range limits
// Revision   : 1.0
// ============================================================================
`default_nettype none

package onehot_pkg;

  localparam int unsigned c_MIN_STATES = 2;
  localparam int unsigned c_MAX_STATES = 32;

  function automatic logic [4:0] onehot_to_idx(input logic [31:0] i_vec);
    logic [4:0] r_idx;
    r_idx = '0;
    // OR of set-bit positions; exact because the vector is one-hot
    for (int i = 0; i < 32; i++) begin
      if (i_vec[i]) r_idx = r_idx | 5'(i);
    end
    return r_idx;
  endfunction

  function automatic logic [31:0] idx_to_onehot(input int unsigned i_idx);
    return 32'd1 << i_idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_chk.sv
// ============================================================================
// onehot_chk : combinational check that exactly one bit of i_vec is set
// Revision   : 1.0
// ============================================================================
`default_nettype none

module onehot_chk #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic             o_legal
);

  logic [WIDTH-1:0] w_low_cleared;

  // Clearing the lowest set bit leaves zero only for a single-bit value
  assign w_low_cleared = i_vec & (i_vec - WIDTH'(1));
  assign o_legal       = (i_vec != '0) && (w_low_cleared == '0);

endmodule

`default_nettype wire

// File: rtl/onehot_state_reg.sv
// ============================================================================
// onehot_state_reg : one-hot state register with illegal-load recovery,
//                    change pulse, sticky error and optional dwell counter
//                    (dwell counter built when ONEHOT_DWELL_CNT_EN is defined)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module onehot_state_reg
  import onehot_pkg::*;
#(
  parameter int unsigned NUM_STATES = 5,
  parameter int unsigned RESET_IDX  = 0,
  parameter int unsigned SAFE_IDX   = 0,
  parameter int unsigned DWELL_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_STATES-1:0]         nxt_state,
  input  logic                          err_clr,
  output logic [NUM_STATES-1:0]         state,
  output logic [$clog2(NUM_STATES)-1:0] state_idx,
  output logic                          changed,
  output logic                          err,
  output logic [DWELL_W-1:0]            dwell
);

  localparam int unsigned c_IDX_W = $clog2(NUM_STATES);

  generate
    if ((NUM_STATES < c_MIN_STATES) || (NUM_STATES > c_MAX_STATES) ||
        (RESET_IDX >= NUM_STATES) || (SAFE_IDX >= NUM_STATES)) begin : g_bad_params
      $error("onehot_state_reg: illegal NUM_STATES/RESET_IDX/SAFE_IDX");
    end
  endgenerate

  localparam logic [NUM_STATES-1:0] c_RESET_VEC = NUM_STATES'(idx_to_onehot(RESET_IDX));
  localparam logic [NUM_STATES-1:0] c_SAFE_VEC  = NUM_STATES'(idx_to_onehot(SAFE_IDX));

  logic [NUM_STATES-1:0] r_state;
  logic                  r_changed;
  logic                  r_err;
  logic                  w_legal;
  logic                  w_illegal_load;
  logic [NUM_STATES-1:0] w_next;
  logic                  w_diff;

  onehot_chk #(
    .WIDTH (NUM_STATES)
  ) u_chk (
    .i_vec   (nxt_state),
    .o_legal (w_legal)
  );

  assign w_illegal_load = en && !w_legal;
  assign w_next         = !en ? r_state : (w_legal ? nxt_state : c_SAFE_VEC);
  assign w_diff         = (w_next != r_state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_RESET_VEC;
      r_changed <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_changed <= w_diff;
      // A coincident illegal load wins over the clear request
      if (w_illegal_load) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

`ifdef ONEHOT_DWELL_CNT_EN
  logic [DWELL_W-1:0] r_dwell;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell <= '0;
    end else if (w_diff) begin
      r_dwell <= '0;
    end else if (r_dwell != {DWELL_W{1'b1}}) begin
      r_dwell <= r_dwell + DWELL_W'(1);
    end
  end

  assign dwell = r_dwell;
`else
  assign dwell = '0;
`endif

  assign state     = r_state;
  assign state_idx = c_IDX_W'(onehot_to_idx(32'(r_state)));
  assign changed   = r_changed;
  assign err       = r_err;

endmodule

`default_nettype wire
